// File: rtl/hsv_learn_ctrl.sv
//-----------------------------------------------------------------------------
// hsv_learn_ctrl
//
// Learning controller for the HSV colour-match binarizer. On a learn request
// it waits for the next frame, averages H, S and V over a square window of
// 2^WIN_LOG2 x 2^WIN_LOG2 pixels centred at (CX, CY), and loads the result
// into the held target register hsv_detect that feeds the binarizer. This
// block owns the only write path to the target colour.
//
// Build option:
//   HSV_LEARN_IIR_EN  when defined, each update writes (old + new_avg) >> 1
//                     per channel (first-order smoothing across learns);
//                     when undefined, each update overwrites with new_avg.
//
// Ports:
//   clk         in   1   pixel clock
//   rst_n       in   1   synchronous active-low reset
//   vsync       in   1   frame sync, rising edge marks a frame boundary
//   de          in   1   active-pixel strobe aligned with hsv_in
//   hsv_in      in  24   {H[23:16], S[15:8], V[7:0]} of the current pixel
//   learn_req   in   1   single-cycle request to capture a new target
//   hsv_detect  out 24   held target colour {H, S, V}
//   learn_busy  out  1   high from request acceptance until the update
//   learn_done  out  1   one-cycle pulse when hsv_detect is updated
//
// Timing: a vsync rise sampled at clock edge E0 that closes the captured
// frame moves the FSM to UPDATE; hsv_detect and learn_done change at the
// following edge E1, i.e. two clock edges after the vsync rise. hsv_detect
// therefore only changes in vertical blanking and is stable over a frame.
//-----------------------------------------------------------------------------
module hsv_learn_ctrl #(
    parameter int          H_ACT       = 640,
    parameter int          V_ACT       = 480,
    parameter int          CX          = 320,
    parameter int          CY          = 240,
    parameter int          WIN_LOG2    = 2,
    parameter logic [23:0] DEFAULT_HSV = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        de,
    input  logic [23:0] hsv_in,
    input  logic        learn_req,
    output logic [23:0] hsv_detect,
    output logic        learn_busy,
    output logic        learn_done
);

    //-------------------------------------------------------------------------
    // Derived constants
    //-------------------------------------------------------------------------
    localparam int XW    = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int YW    = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    // Accumulator holds 4^WIN_LOG2 samples of 8 bits without overflow.
    localparam int ACC_W = 8 + 2 * WIN_LOG2;
    // Sample counter must be able to represent 4^WIN_LOG2 itself.
    localparam int CNT_W = 2 * WIN_LOG2 + 1;
    localparam int HALF  = 1 << (WIN_LOG2 - 1);

    localparam logic [XW-1:0]    X_MAX = XW'(H_ACT - 1);
    localparam logic [YW-1:0]    Y_MAX = YW'(V_ACT - 1);
    localparam logic [XW-1:0]    X_LO  = XW'(CX - HALF);
    localparam logic [XW-1:0]    X_HI  = XW'(CX + HALF - 1);
    localparam logic [YW-1:0]    Y_LO  = YW'(CY - HALF);
    localparam logic [YW-1:0]    Y_HI  = YW'(CY + HALF - 1);
    localparam logic [CNT_W-1:0] NSAMP = CNT_W'(1 << (2 * WIN_LOG2));

    //-------------------------------------------------------------------------
    // FSM state encoding
    //-------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_ACCUM  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    //-------------------------------------------------------------------------
    // Registers
    //-------------------------------------------------------------------------
    logic               r_vsync_d;
    logic               r_de_d;
    logic [XW-1:0]      r_x_cnt;
    logic [YW-1:0]      r_y_cnt;
    logic [CNT_W-1:0]   r_smp_cnt;
    logic [23:0]        r_hsv_detect;
    logic               r_learn_busy;
    logic               r_learn_done;

    //-------------------------------------------------------------------------
    // Combinational control
    //-------------------------------------------------------------------------
    logic               w_vs_rise;
    logic               w_de_fall;
    logic               w_in_win;
    logic               w_acc_clr;
    logic               w_acc_en;
    logic               w_update;
    logic               w_accept;
    logic [23:0]        w_hsv_new;

    // Both edges compare the live input against its one-cycle delay, so the
    // edge is seen in the same cycle the input first changes.
    assign w_vs_rise = vsync & ~r_vsync_d;
    assign w_de_fall = ~de & r_de_d;

    // x_cnt equals the active-pixel index of the pixel currently on hsv_in,
    // y_cnt the active-line index, so membership is a direct range test.
    assign w_in_win = de
                    && (r_x_cnt >= X_LO) && (r_x_cnt <= X_HI)
                    && (r_y_cnt >= Y_LO) && (r_y_cnt <= Y_HI);

    // A request is only taken from IDLE; requests while busy are dropped.
    assign w_accept = (r_state == S_IDLE) && learn_req;

    //-------------------------------------------------------------------------
    // Edge-detect delay registers
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b0;
            r_de_d    <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_de_d    <= de;
        end
    end

    //-------------------------------------------------------------------------
    // Position counters: free-running in every FSM state, saturating so a
    // malformed (over-long) line or frame cannot wrap back into the window.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else begin
            if (w_de_fall) begin
                r_x_cnt <= '0;
            end else if (de && (r_x_cnt != X_MAX)) begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end

            if (w_vs_rise) begin
                r_y_cnt <= '0;
            end else if (w_de_fall && (r_y_cnt != Y_MAX)) begin
                r_y_cnt <= r_y_cnt + 1'b1;
            end
        end
    end

    //-------------------------------------------------------------------------
    // FSM state register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //-------------------------------------------------------------------------
    // FSM next-state and control decode
    //-------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_acc_clr    = 1'b0;
        w_acc_en     = 1'b0;
        w_update     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A vs_rise coinciding with the request is not used as the
                // capture start; ARM waits for the next one.
                if (learn_req) begin
                    w_state_next = S_ARM;
                end
            end

            S_ARM: begin
                if (w_vs_rise) begin
                    w_acc_clr    = 1'b1;
                    w_state_next = S_ACCUM;
                end
            end

            S_ACCUM: begin
                // Frame end wins over an in-window pixel in the same cycle.
                if (w_vs_rise) begin
                    if (r_smp_cnt == NSAMP) begin
                        w_state_next = S_UPDATE;
                    end else begin
                        // Short or truncated frame: retry on the next one.
                        w_acc_clr = 1'b1;
                    end
                end else if (w_in_win && (r_smp_cnt != NSAMP)) begin
                    // The count guard keeps the accumulators in range even
                    // if the video timing repeats window coordinates.
                    w_acc_en = 1'b1;
                end
            end

            S_UPDATE: begin
                w_update     = 1'b1;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // Sample counter
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_smp_cnt <= '0;
        end else if (w_acc_clr) begin
            r_smp_cnt <= '0;
        end else if (w_acc_en) begin
            r_smp_cnt <= r_smp_cnt + 1'b1;
        end
    end

    //-------------------------------------------------------------------------
    // Per-channel accumulators and new-target computation.
    // Channel gi occupies hsv bits [gi*8 +: 8]: 2 = H, 1 = S, 0 = V.
    //-------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [ACC_W-1:0] r_acc;
            logic [7:0]       w_avg;
            logic [7:0]       w_new;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_acc <= '0;
                end else if (w_acc_clr) begin
                    r_acc <= '0;
                end else if (w_acc_en) begin
                    r_acc <= r_acc + ACC_W'(hsv_in[gi*8 +: 8]);
                end
            end

            // Dividing by 4^WIN_LOG2 is taking the top 8 bits (truncating).
            // Hue is averaged linearly: no wrap-around handling near 0/255.
            assign w_avg = r_acc[ACC_W-1 -: 8];

`ifdef HSV_LEARN_IIR_EN
            // Smoothing: halfway between the held target and the new average,
            // computed with a 9-bit sum so the carry is kept before halving.
            logic [8:0] w_sum;
            assign w_sum = {1'b0, r_hsv_detect[gi*8 +: 8]} + {1'b0, w_avg};
            assign w_new = 8'(w_sum >> 1);
`else
            assign w_new = w_avg;
`endif

            assign w_hsv_new[gi*8 +: 8] = w_new;
        end
    endgenerate

    //-------------------------------------------------------------------------
    // Output registers: target colour, busy flag and done pulse.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsv_detect <= DEFAULT_HSV;
            r_learn_busy <= 1'b0;
            r_learn_done <= 1'b0;
        end else begin
            r_learn_done <= w_update;

            if (w_update) begin
                r_hsv_detect <= w_hsv_new;
            end

            if (w_accept) begin
                r_learn_busy <= 1'b1;
            end else if (w_update) begin
                r_learn_busy <= 1'b0;
            end
        end
    end

    assign hsv_detect = r_hsv_detect;
    assign learn_busy = r_learn_busy;
    assign learn_done = r_learn_done;

endmodule

// File: tb/tb_hsv_learn_ctrl.sv
//-----------------------------------------------------------------------------
// Testbench for hsv_learn_ctrl with a reduced 16x8 raster, window centre
// (8, 4) and a 2x2 window. Expected targets are pushed to a scoreboard when
// a learn request is issued and popped when learn_done is observed.
//-----------------------------------------------------------------------------
module tb_hsv_learn_ctrl;

    localparam int          H   = 16;
    localparam int          V   = 8;
    localparam int          CXP = 8;
    localparam int          CYP = 4;
    localparam int          WL  = 1;
    localparam logic [23:0] DEF = 24'h123456;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        de = 1'b0;
    logic [23:0] hsv_in = '0;
    logic        learn_req = 1'b0;
    logic [23:0] hsv_detect;
    logic        learn_busy;
    logic        learn_done;

    hsv_learn_ctrl #(
        .H_ACT       (H),
        .V_ACT       (V),
        .CX          (CXP),
        .CY          (CYP),
        .WIN_LOG2    (WL),
        .DEFAULT_HSV (DEF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .de         (de),
        .hsv_in     (hsv_in),
        .learn_req  (learn_req),
        .hsv_detect (hsv_detect),
        .learn_busy (learn_busy),
        .learn_done (learn_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [23:0] sb[$];
    logic [23:0] model_hsv = DEF;
    int          vs_cyc = 0;
    int          done_cnt = 0;
    bit          track_busy = 1'b0;
    int          busy_drops = 0;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pixel source. Mode 0: constant colour c. Mode 1: the truncation
    // pattern inside the window, black elsewhere.
    function automatic logic [23:0] pix(input int mode, input logic [23:0] c,
                                        input int x, input int y);
        if (mode == 0) return c;
        if (x == CXP-1 && y == CYP-1) return 24'h0A00FF;
        if (x == CXP   && y == CYP-1) return 24'h1400FF;
        if (x == CXP-1 && y == CYP  ) return 24'h1E00FF;
        if (x == CXP   && y == CYP  ) return 24'h2903FF;
        return 24'h000000;
    endfunction

    // Truncated mean of the window content as the bench drives it.
    function automatic logic [23:0] exp_avg(input int mode, input logic [23:0] c);
        int sh = 0, ss = 0, sv = 0;
        int half = 1 << (WL - 1);
        logic [23:0] p;
        for (int y = CYP - half; y < CYP + half; y++) begin
            for (int x = CXP - half; x < CXP + half; x++) begin
                p = pix(mode, c, x, y);
                sh += int'(p[23:16]);
                ss += int'(p[15:8]);
                sv += int'(p[7:0]);
            end
        end
        return {8'(sh >> (2*WL)), 8'(ss >> (2*WL)), 8'(sv >> (2*WL))};
    endfunction

    function automatic logic [23:0] next_target(input logic [23:0] old, input logic [23:0] avg);
`ifdef HSV_LEARN_IIR_EN
        logic [23:0] r;
        for (int ch = 0; ch < 3; ch++) begin
            r[ch*8 +: 8] = 8'((int'(old[ch*8 +: 8]) + int'(avg[ch*8 +: 8])) >> 1);
        end
        return r;
`else
        return (old & 24'h0) | avg;
`endif
    endfunction

    // Done monitor: pops the scoreboard, checks latency and busy hold.
    always @(negedge clk) begin
        if (rst_n && learn_done) begin
            done_cnt++;
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_done: observed learn_done with empty scoreboard, expected none");
            end
            if (sb.size() != 0) chk("hsv_detect_update", hsv_detect, sb.pop_front());
            chk_int("done_latency", cyc - vs_cyc, 1);
            chk_int("busy_held", busy_drops, 0);
            chk_int("busy_clear_at_done", int'(learn_busy), 0);
            $display("[TB] learn_done at cycle %0d hsv_detect=%h", cyc, hsv_detect);
            track_busy = 1'b0;
            busy_drops = 0;
        end else if (rst_n && track_busy && learn_busy !== 1'b1) begin
            busy_drops++;
        end
    end

    // One frame: vsync pulse, blanking, then nlines active lines.
    task automatic frame(input int mode, input logic [23:0] c, input int nlines);
        vsync  = 1'b1;
        vs_cyc = cyc + 1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < H; x++) begin
                de     = 1'b1;
                hsv_in = pix(mode, c, x, y);
                @(negedge clk);
            end
            de     = 1'b0;
            hsv_in = '0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic learn(input int mode, input logic [23:0] c, input bit push);
        learn_req = 1'b1;
        @(negedge clk);
        learn_req = 1'b0;
        if (push) begin
            model_hsv = next_target(model_hsv, exp_avg(mode, c));
            sb.push_back(model_hsv);
            track_busy = 1'b1;
            busy_drops = 0;
        end
        $display("[TB] learn_req mode=%0d colour=%h push=%0d", mode, c, push);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hsv", hsv_detect, DEF);
        chk_int("reset_busy", int'(learn_busy), 0);
        chk_int("reset_done", int'(learn_done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Constant frame
        learn(0, 24'h5A80C0, 1'b1);
        chk_int("busy_after_req", int'(learn_busy), 1);
        d0 = done_cnt;
        frame(0, 24'h5A80C0, V);
        chk_int("no_done_arm_frame", done_cnt - d0, 0);
        frame(0, 24'h5A80C0, V);
        chk_int("const_done_count", done_cnt - d0, 1);
        chk("const_hsv_held", hsv_detect, model_hsv);
        chk_int("const_busy_low", int'(learn_busy), 0);

        // Averaging with truncation
        d0 = done_cnt;
        learn(1, 24'h0, 1'b1);
        frame(1, 24'h0, V);
        frame(0, 24'h0, V);
        chk_int("avg_done_count", done_cnt - d0, 1);
        chk("avg_hsv_held", hsv_detect, model_hsv);

        // Short frame retry
        d0 = done_cnt;
        learn(0, 24'h336699, 1'b1);
        frame(0, 24'h336699, 3);
        frame(0, 24'h336699, V);
        chk_int("short_no_done", done_cnt - d0, 0);
        chk_int("short_busy_high", int'(learn_busy), 1);
        frame(0, 24'h336699, V);
        chk_int("retry_done_count", done_cnt - d0, 1);
        chk("retry_hsv_held", hsv_detect, model_hsv);

        // Second request while busy is ignored
        d0 = done_cnt;
        learn(0, 24'hC01020, 1'b1);
        frame(0, 24'hC01020, V);
        learn(0, 24'hC01020, 1'b0);
        frame(0, 24'hC01020, V);
        frame(0, 24'hC01020, V);
        chk_int("busy_ignore_one_done", done_cnt - d0, 1);

        // Reset during ACCUM discards the capture
        learn(0, 24'h0F0F0F, 1'b1);
        frame(0, 24'h0F0F0F, V);
        rst_n = 1'b0;
        sb.delete();
        track_busy = 1'b0;
        model_hsv  = DEF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("midop_reset_hsv", hsv_detect, DEF);
        d0 = done_cnt;
        frame(0, 24'h0F0F0F, V);
        frame(0, 24'h0F0F0F, V);
        chk_int("midop_no_done", done_cnt - d0, 0);
        chk("midop_hsv_default", hsv_detect, DEF);
        chk_int("midop_busy_low", int'(learn_busy), 0);

        chk_int("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
